// File: rtl/operand_sequencer.sv
// Operand sequencer: a command FIFO feeds a four-state FSM that loads the a/b/c
// operands, pulses issue, waits DELAY cycles and samples the downstream z result.
module operand_sequencer #(
  parameter int DEPTH = 4,
  parameter int DELAY = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] in_data,
  input  logic       in_valid,
  output logic       in_ready,
  output logic [3:0] a,
  output logic [3:0] b,
  output logic [3:0] c,
  output logic       issue,
  input  logic       z,
  output logic       res_valid,
  output logic       res_z,
  output logic [7:0] ones_cnt,
  output logic       busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_SAMPLE
  } state_t;

  state_t             r_state;
  state_t             w_state_next;

  // Bits [5:4] of a command carry no meaning, so only op and arg are stored.
  logic [5:0]         r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic [3:0]         r_a;
  logic [3:0]         r_b;
  logic [3:0]         r_c;
  logic [4:0]         r_rep;
  logic [3:0]         r_timer;
  logic [7:0]         r_ones;

  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [5:0]         w_head;
  logic [1:0]         w_op;
  logic [3:0]         w_arg;
  logic               w_unused_bits;

  assign w_unused_bits = ^in_data[5:4];

  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;
  assign w_head   = r_mem[r_rd_ptr];
  assign w_op     = w_head[5:4];
  assign w_arg    = w_head[3:0];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_data[7:6], in_data[3:0]};
    end
  end

  // Power-of-two depth lets the pointers wrap by natural overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!w_empty) begin
          w_pop = 1'b1;
          if (w_op == 2'b11) w_state_next = S_ISSUE;
        end
      end
      S_ISSUE:  w_state_next = S_WAIT;
      // Timer counts DELAY..1, so exactly DELAY cycles are spent here.
      S_WAIT:   if (r_timer == 4'd1) w_state_next = S_SAMPLE;
      S_SAMPLE: w_state_next = (r_rep > 5'd1) ? S_ISSUE : S_IDLE;
      default:  w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a     <= '0;
      r_b     <= '0;
      r_c     <= '0;
      r_rep   <= '0;
      r_timer <= '0;
      r_ones  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            case (w_op)
              2'b00:   r_a <= w_arg;
              2'b01:   r_b <= w_arg;
              2'b10:   r_c <= w_arg;
              default: r_rep <= (w_arg == 4'd0) ? 5'd16 : {1'b0, w_arg};
            endcase
          end
        end
        S_ISSUE: r_timer <= 4'(DELAY);
        S_WAIT:  r_timer <= r_timer - 4'd1;
        S_SAMPLE: begin
          r_rep <= r_rep - 5'd1;
          if (z && (r_ones != 8'hFF)) r_ones <= r_ones + 8'd1;
        end
        default: ;
      endcase
    end
  end

  assign a         = r_a;
  assign b         = r_b;
  assign c         = r_c;
  assign ones_cnt  = r_ones;
  assign issue     = (r_state == S_ISSUE);
  assign res_valid = (r_state == S_SAMPLE);
  assign res_z     = res_valid && z;
  assign busy      = !w_empty || (r_state != S_IDLE);

endmodule

// File: doc/operand_sequencer.md
OPERAND_SEQUENCER -- requirements
Module: operand_sequencer

Interface
REQ-001 Parameter DEPTH, default 4: command FIFO entries; power of two, 2..16.
REQ-002 Parameter DELAY, default 4: WAIT cycles between operand issue and z sample; 1..15.
REQ-003 CLK  input  1  single clock; all state changes on rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 in_data  input  8  command byte.
REQ-006 in_valid  input  1  in_data valid.
REQ-007 in_ready  output  1  FIFO can accept a byte.
REQ-008 a, b, c  output  4 each  operand registers feeding the downstream reduction stage.
REQ-009 issue  output  1  one-cycle pulse; operands are valid for a new evaluation.
REQ-010 z  input  1  result from the downstream stage.
REQ-011 res_valid  output  1  one-cycle pulse; res_z is valid.
REQ-012 res_z  output  1  sampled z.
REQ-013 ones_cnt  output  8  count of samples with z=1.
REQ-014 busy  output  1  FIFO non-empty or FSM not in IDLE.

Function
REQ-015 Command format: [7:6] op, [5:4] ignored, [3:0] arg.
- op 00: load a. op 01: load b. op 10: load c.
- op 11: issue, arg times; arg=0 means 16.
REQ-016 in_ready SHALL equal FIFO not full; a push occurs when in_valid & in_ready; no bypass path.
REQ-017 FSM states IDLE, ISSUE, WAIT, SAMPLE; state encoding is free.
REQ-018 IDLE with FIFO empty: remain in IDLE, no pop.
REQ-019 IDLE with FIFO non-empty: pop the head in this cycle.
- Load ops: update the target register at the closing edge; stay in IDLE (one command per cycle).
- Issue op: rep <= arg (0 maps to 16); go to ISSUE.
REQ-020 ISSUE: issue=1 for exactly one cycle; timer <= DELAY; go to WAIT.
REQ-021 WAIT: decrement the timer each cycle; go to SAMPLE after exactly DELAY WAIT cycles.
REQ-022 SAMPLE (one cycle):
- res_valid=1 and res_z=z, combinational from state and z.
- ones_cnt increments when z=1 and saturates at 255.
- rep decrements; go to ISSUE if rep was >1, else to IDLE.
REQ-023 Timing: issue in cycle t, res_valid in cycle t+DELAY+1; back-to-back repeats have issue pulses DELAY+2 cycles apart.
REQ-024 Pops occur only in IDLE; pushes continue in all states while in_ready=1.
REQ-025 Push and pop in the same cycle leaves occupancy unchanged; pointers wrap modulo DEPTH.
REQ-026 a, b and c are stable from the ISSUE cycle through SAMPLE; loads queued behind an issue command do not take effect until the issue completes.
REQ-027 ones_cnt clears only on reset.

Reset
REQ-028 RST_N low asserts reset asynchronously, mid-operation included:
- FSM to IDLE; FIFO emptied.
- a, b, c, rep, timer and ones_cnt cleared to 0.
REQ-029 Output values during reset: issue=0, res_valid=0, res_z=0, busy=0, in_ready=1.
REQ-030 After release, the first push is accepted at the first rising edge where RST_N is high.

Verification (DELAY=4, DEPTH=4; bench model z = a[0]&b[0]&c[0])
REQ-031 Push 0x0F, 0x4F, 0x8F, 0xC2 -> a=b=c=0xF; two issue pulses 6 cycles apart; two res_valid pulses with res_z=1; ones_cnt=2.
REQ-032 Push 0x0E, 0xC0 -> 16 issue pulses, 16 res_valid pulses with res_z=0, ones_cnt=0, then busy drops to 0.
REQ-033 Hold in_valid=1 with an issue command at the FIFO head plus 4 more bytes queued behind it -> in_ready=0 once 4 entries are held; no byte is lost or duplicated; pops resume in IDLE.
REQ-034 Run 300 samples with z=1 -> ones_cnt saturates at 255 and does not wrap.
REQ-035 Drop RST_N in WAIT -> issue, res_valid and busy are 0 immediately; ones_cnt=0; a, b, c=0; no res_valid pulse after release.
REQ-036 Push 0x03, then 0xC1, then 0x05 while the issue is in WAIT -> res_valid samples with a=3; a becomes 5 only after the FSM returns to IDLE.
